sevenseg_mux: RTL and testbench

SEVENSEG_MUX -- requirements
Module: sevenseg_mux

---
 rtl/sevenseg_pkg.sv | 23 ++
 rtl/sevenseg_if.sv | 25 ++
 rtl/sevenseg_decode.sv | 36 +++
 rtl/sevenseg_mux.sv | 129 ++++++++++++
 tb/tb_sevenseg_mux.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// Shared segment patterns for the seven-segment multiplexer, in logical polarity {g,f,e,d,c,b,a}.
// Codes 10..15 are only used by the decoder when SEVENSEG_HEX_EN is defined.
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;

endpackage

// File: rtl/sevenseg_if.sv
// Data/display bundle of the seven-segment multiplexer; the host side is the master,
// the multiplexer is the slave.
interface sevenseg_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   bcd_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      blank_lz;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;
    logic                      pending;

    modport master (
        output load, bcd_in, dp_in, blank_lz,
        input  seg, dp, an, frame_done, pending
    );

    modport slave (
        input  load, bcd_in, dp_in, blank_lz,
        output seg, dp, an, frame_done, pending
    );
endinterface

// File: rtl/sevenseg_decode.sv
// Combinational 4-bit code to logical segment pattern.
// Build option: define SEVENSEG_HEX_EN to show A..F for codes 10..15 (blank otherwise).
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:  seg = SEG_0;
            4'd1:  seg = SEG_1;
            4'd2:  seg = SEG_2;
            4'd3:  seg = SEG_3;
            4'd4:  seg = SEG_4;
            4'd5:  seg = SEG_5;
            4'd6:  seg = SEG_6;
            4'd7:  seg = SEG_7;
            4'd8:  seg = SEG_8;
            4'd9:  seg = SEG_9;
`ifdef SEVENSEG_HEX_EN
            4'd10: seg = SEG_A;
            4'd11: seg = SEG_B;
            4'd12: seg = SEG_C;
            4'd13: seg = SEG_D;
            4'd14: seg = SEG_E;
            4'd15: seg = SEG_F;
`else
            default: seg = SEG_BLANK;
`endif
        endcase
    end

endmodule

// File: rtl/sevenseg_mux.sv
// Time-multiplexed seven-segment driver with frame-synchronous data update and leading-zero blanking.
// Build option: SEVENSEG_HEX_EN (hex digits, handled inside sevenseg_decode).
module sevenseg_mux
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    sevenseg_if.slave  bus
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = 4 * NUM_DIGITS;
    localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx, idx_next;
    logic [BW-1:0]         disp_bcd, disp_bcd_next, shd_bcd, shd_bcd_next;
    logic [NUM_DIGITS-1:0] disp_dp, disp_dp_next, shd_dp, shd_dp_next;
    logic                  disp_blz, disp_blz_next, shd_blz, shd_blz_next;
    logic                  pending_q, pending_next, frame_q;
    logic                  tick, wrap;
    logic [3:0]            sel_code;
    logic                  sel_blank, sel_dp, zero_run;
    logic [NUM_DIGITS-1:0] an_log, an_q;
    logic [6:0]            dec_seg, seg_log, seg_q;
    logic                  dp_q;

    assign tick     = (presc == PW'(REFRESH_DIV - 1));
    assign wrap     = tick && (idx == IW'(NUM_DIGITS - 1));
    assign idx_next = tick ? (wrap ? '0 : idx + IW'(1)) : idx;

    // A load landing on the frame boundary bypasses the shadow entirely
    always_comb begin
        disp_bcd_next = disp_bcd;
        disp_dp_next  = disp_dp;
        disp_blz_next = disp_blz;
        shd_bcd_next  = shd_bcd;
        shd_dp_next   = shd_dp;
        shd_blz_next  = shd_blz;
        pending_next  = pending_q;
        if (bus.load && wrap) begin
            disp_bcd_next = bus.bcd_in;
            disp_dp_next  = bus.dp_in;
            disp_blz_next = bus.blank_lz;
            pending_next  = 1'b0;
        end else if (wrap && pending_q) begin
            disp_bcd_next = shd_bcd;
            disp_dp_next  = shd_dp;
            disp_blz_next = shd_blz;
            pending_next  = 1'b0;
        end else if (bus.load) begin
            shd_bcd_next  = bus.bcd_in;
            shd_dp_next   = bus.dp_in;
            shd_blz_next  = bus.blank_lz;
            pending_next  = 1'b1;
        end
    end

    // Outputs are built from next-state values so they move together with the index
    always_comb begin
        sel_code  = 4'd0;
        sel_blank = 1'b0;
        sel_dp    = 1'b0;
        zero_run  = 1'b1;
        an_log    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (disp_bcd_next[4*k +: 4] == 4'd0);
            an_log[k] = (idx_next == IW'(k));
            if (idx_next == IW'(k)) begin
                sel_code  = disp_bcd_next[4*k +: 4];
                sel_dp    = disp_dp_next[k];
                sel_blank = disp_blz_next && (k != 0) && zero_run;
            end
        end
    end

    sevenseg_decode u_decode (
        .code (sel_code),
        .seg  (dec_seg)
    );

    assign seg_log = sel_blank ? SEG_BLANK : dec_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            idx       <= '0;
            disp_bcd  <= '0;
            disp_dp   <= '0;
            disp_blz  <= 1'b0;
            shd_bcd   <= '0;
            shd_dp    <= '0;
            shd_blz   <= 1'b0;
            pending_q <= 1'b0;
            frame_q   <= 1'b0;
            seg_q     <= SEG_OFF;
            dp_q      <= DP_OFF;
            an_q      <= AN_OFF;
        end else begin
            presc     <= tick ? '0 : presc + PW'(1);
            idx       <= idx_next;
            disp_bcd  <= disp_bcd_next;
            disp_dp   <= disp_dp_next;
            disp_blz  <= disp_blz_next;
            shd_bcd   <= shd_bcd_next;
            shd_dp    <= shd_dp_next;
            shd_blz   <= shd_blz_next;
            pending_q <= pending_next;
            frame_q   <= wrap;
            seg_q     <= seg_log ^ SEG_OFF;
            dp_q      <= sel_dp ^ DP_OFF;
            an_q      <= an_log ^ AN_OFF;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Directed plus randomized bench for sevenseg_mux (4 digits, 4-cycle slots, active-high pins),
// checked against a cycle-count based reference model. Honours SEVENSEG_HEX_EN.
module tb_sevenseg_mux;

    localparam int N = 4;
    localparam int D = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    sevenseg_if #(.NUM_DIGITS(N)) bus ();

    sevenseg_mux #(.NUM_DIGITS(N), .REFRESH_DIV(D), .ACTIVE_LOW(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edges since reset release plus display/shadow contents
    int          m;
    logic [15:0] m_disp, m_shd;
    logic [3:0]  m_ddp, m_sdp;
    bit          m_dblz, m_sblz, m_pend, m_wrap;
    logic [6:0]  seg_tab [16];

    task automatic model_reset();
        m = 0; m_disp = '0; m_shd = '0; m_ddp = '0; m_sdp = '0;
        m_dblz = 0; m_sblz = 0; m_pend = 0; m_wrap = 0;
    endtask

    task automatic model_edge(input bit ld, input logic [15:0] b, input logic [3:0] d, input bit z);
        m++;
        m_wrap = (m % (D * N)) == 0;
        if (ld && m_wrap) begin
            m_disp = b; m_ddp = d; m_dblz = z; m_pend = 0;
        end else if (m_wrap && m_pend) begin
            m_disp = m_shd; m_ddp = m_sdp; m_dblz = m_sblz; m_pend = 0;
        end else if (ld) begin
            m_shd = b; m_sdp = d; m_sblz = z; m_pend = 1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, m);
        end
    endtask

    task automatic check_output();
        int k;
        logic [15:0] upper;
        logic [6:0]  e_seg;
        if (!rst_n || m == 0) begin
            check("an", 16'(bus.an), 16'h0);
            check("seg", 16'(bus.seg), 16'h0);
            check("dp", 16'(bus.dp), 16'h0);
            check("frame_done", 16'(bus.frame_done), 16'h0);
            check("pending", 16'(bus.pending), 16'h0);
        end else begin
            k = (m / D) % N;
            upper = m_disp >> (4 * k);
            e_seg = (m_dblz && k > 0 && upper == 0) ? 7'h00 : seg_tab[upper[3:0]];
            check("an", 16'(bus.an), 16'(1 << k));
            check("seg", 16'(bus.seg), 16'(e_seg));
            check("dp", 16'(bus.dp), 16'(m_ddp[k]));
            check("frame_done", 16'(bus.frame_done), 16'(m_wrap));
            check("pending", 16'(bus.pending), 16'(m_pend));
        end
    endtask

    task automatic apply_stimulus(input bit ld, input logic [15:0] b, input logic [3:0] d, input bit z);
        bus.load = ld; bus.bcd_in = b; bus.dp_in = d; bus.blank_lz = z;
        @(posedge clk);
        model_edge(ld, b, d, z);
        #1;
        bus.load = 1'b0;
        check_output();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < 2 * D * N && ((m + 1) % (D * N)) != phase; i++) idle(1);
    endtask

    initial begin
        seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                    7'b1111111, 7'b1101111, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`ifdef SEVENSEG_HEX_EN
        seg_tab[10] = 7'b1110111; seg_tab[11] = 7'b1111100; seg_tab[12] = 7'b0111001;
        seg_tab[13] = 7'b1011110; seg_tab[14] = 7'b1111001; seg_tab[15] = 7'b1110001;
`endif
        vectors = 0;
        miscompares = 0;
        model_reset();
        bus.load = 1'b0; bus.bcd_in = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
        rst_n = 1'b0;
        #2;
        check_output();
        repeat (2) @(posedge clk);
        #1;
        check_output();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] idle rotation");
        idle(40);

        $display("[TB] mid-frame load 1234");
        idle_until(6);
        apply_stimulus(1'b1, 16'h1234, 4'b0100, 1'b0);
        idle(24);

        $display("[TB] last load wins");
        idle_until(3);
        apply_stimulus(1'b1, 16'h0042, 4'b0000, 1'b0);
        idle(3);
        apply_stimulus(1'b1, 16'h0007, 4'b0000, 1'b0);
        idle(24);

        $display("[TB] leading-zero blanking");
        apply_stimulus(1'b1, 16'h0050, 4'b1000, 1'b1);
        idle(24);

        $display("[TB] hex codes");
        apply_stimulus(1'b1, 16'hABCD, 4'b0001, 1'b0);
        idle(24);

        $display("[TB] load on wrapping tick, then reset mid-frame");
        idle_until(0);
        apply_stimulus(1'b1, 16'h9876, 4'b1010, 1'b0);
        idle(6);
        apply_stimulus(1'b1, 16'h0321, 4'b0011, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output();
        repeat (2) @(posedge clk);
        #1;
        check_output();
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        $display("[TB] randomized loads");
        for (int i = 0; i < 500; i++) begin
            apply_stimulus($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
